// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops RATIO narrow words and packs them into one wide word
// presented on a valid/ready stream, with flush emitting a partially filled word.
module fifo_rd_packer #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned RATIO  = 4,
    parameter int unsigned CWIDTH = 16
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [DSIZE-1:0]       rdata,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CWIDTH-1:0]      word_cnt
);

    localparam int unsigned CntW = $clog2(RATIO + 1);
    localparam int unsigned OutW = DSIZE * RATIO;

    logic [OutW-1:0]   asm_data_q, asm_data_d;
    logic [CntW-1:0]   asm_cnt_q, asm_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [OutW-1:0]   m_data_q, m_data_d;
    logic [RATIO-1:0]  m_keep_q, m_keep_d;
    logic              m_last_q, m_last_d;
    logic              m_valid_q, m_valid_d;
    logic [CWIDTH-1:0] word_cnt_q, word_cnt_d;

    logic             asm_full, asm_rdy, xfer, pop;
    logic [CntW-1:0]  wr_lane;
    logic [RATIO-1:0] keep_c;

    always_comb begin
        asm_full = (asm_cnt_q == CntW'(RATIO));
        asm_rdy  = asm_full | (flush_pend_q & (asm_cnt_q != '0));
        xfer     = asm_rdy & (~m_valid_q | m_ready);
        pop      = ~rrst & ~rempty & ~flush_pend_q & (~asm_full | xfer);
        rinc     = pop;
        for (int i = 0; i < int'(RATIO); i++) begin
            keep_c[i] = (CntW'(i) < asm_cnt_q);
        end
    end

    // Assembly lanes beyond asm_cnt are always zero: cleared on every transfer and on reset.
    always_comb begin
        asm_data_d = asm_data_q;
        asm_cnt_d  = asm_cnt_q;
        wr_lane    = xfer ? '0 : asm_cnt_q;
        if (xfer) begin
            asm_data_d = '0;
            asm_cnt_d  = '0;
        end
        if (pop) begin
            for (int i = 0; i < int'(RATIO); i++) begin
                if (wr_lane == CntW'(i)) begin
                    asm_data_d[i*DSIZE +: DSIZE] = rdata;
                end
            end
            asm_cnt_d = wr_lane + CntW'(1);
        end
    end

    always_comb begin
        flush_pend_d = flush_pend_q ? ~(xfer | (asm_cnt_q == '0)) : flush;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;
        word_cnt_d   = word_cnt_q;
        if (xfer) begin
            m_data_d  = asm_data_q;
            m_keep_d  = keep_c;
            m_last_d  = flush_pend_q;
            m_valid_d = 1'b1;
        end else if (m_valid_q & m_ready) begin
            m_valid_d = 1'b0;
        end
        if (m_valid_q & m_ready) begin
            word_cnt_d = word_cnt_q + CWIDTH'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            asm_data_q   <= '0;
            asm_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            asm_data_q   <= asm_data_d;
            asm_cnt_q    <= asm_cnt_d;
            flush_pend_q <= flush_pend_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_keep   = m_keep_q;
    assign m_last   = m_last_q;
    assign m_valid  = m_valid_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the FIFO source and the packing rules.
module tb_fifo_rd_packer;

    localparam int unsigned DSIZE  = 8;
    localparam int unsigned RATIO  = 4;
    localparam int unsigned CWIDTH = 16;

    logic                   rclk = 1'b0;
    logic                   rrst;
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [DSIZE*RATIO-1:0] m_data;
    logic [RATIO-1:0]       m_keep;
    logic                   m_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [CWIDTH-1:0]      word_cnt;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE  (DSIZE),
        .RATIO  (RATIO),
        .CWIDTH (CWIDTH)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .flush    (flush),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .word_cnt (word_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int rinc_seen = 0;

    // Model state: FIFO contents, words gathered so far, and the output register.
    logic [DSIZE-1:0]       src_q[$];
    logic [DSIZE-1:0]       asm_q[$];
    bit                     fp_m;
    bit                     mv_m;
    bit                     ml_m;
    logic [DSIZE*RATIO-1:0] md_m;
    logic [RATIO-1:0]       mk_m;
    logic [CWIDTH-1:0]      wc_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit fl, input bit rdy);
        int cnt;
        bit word_ready, xf, pop, accept, new_fp;
        @(negedge rclk);
        rrst    = rst;
        flush   = fl;
        m_ready = rdy;
        rempty  = (src_q.size() == 0);
        rdata   = rempty ? DSIZE'($urandom) : src_q[0];
        cnt        = asm_q.size();
        word_ready = (cnt == int'(RATIO)) || (fp_m && cnt != 0);
        xf         = word_ready && (!mv_m || rdy);
        pop        = !rst && src_q.size() > 0 && !fp_m && (cnt < int'(RATIO) || xf);
        accept     = mv_m && rdy;
        #1;
        if (rinc === 1'b1) rinc_seen++;
        check_eq("rinc", 64'(rinc), 64'(pop));
        check_eq("m_valid", 64'(m_valid), 64'(mv_m));
        check_eq("m_data", 64'(m_data), 64'(md_m));
        check_eq("m_keep", 64'(m_keep), 64'(mk_m));
        check_eq("m_last", 64'(m_last), 64'(ml_m));
        check_eq("word_cnt", 64'(word_cnt), 64'(wc_m));
        @(posedge rclk);
        if (rst) begin
            asm_q.delete();
            fp_m = 0; mv_m = 0; ml_m = 0; md_m = '0; mk_m = '0; wc_m = '0;
        end else begin
            if (accept) wc_m = wc_m + 1'b1;
            new_fp = fp_m ? !(xf || cnt == 0) : fl;
            if (xf) begin
                md_m = '0;
                foreach (asm_q[i]) md_m[i*DSIZE +: DSIZE] = asm_q[i];
                mk_m = RATIO'((1 << cnt) - 1);
                ml_m = fp_m;
                mv_m = 1;
                asm_q.delete();
            end else if (accept) begin
                mv_m = 0;
            end
            fp_m = new_fp;
            if (pop) asm_q.push_back(src_q.pop_front());
        end
    endtask

    initial begin
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = '0;
        fp_m = 0; mv_m = 0; ml_m = 0; md_m = '0; mk_m = '0; wc_m = '0;
        repeat (2) @(posedge rclk);

        // Reset held with a non-empty FIFO: no pops, outputs zero.
        src_q.push_back(8'h5A);
        repeat (2) step(1, 0, 1);
        src_q.delete();
        step(0, 0, 1);

        // Streaming 01..08 with the sink always ready.
        for (int i = 1; i <= 8; i++) src_q.push_back(DSIZE'(i));
        repeat (12) step(0, 0, 1);
        #1 check_eq("t2_word_cnt", 64'(word_cnt), 64'd2);

        // Partial word closed by flush.
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        repeat (2) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        #1;
        check_eq("t3_valid", 64'(m_valid), 64'd1);
        check_eq("t3_data", 64'(m_data), 64'h0000BBAA);
        check_eq("t3_keep", 64'(m_keep), 64'h3);
        check_eq("t3_last", 64'(m_last), 64'd1);
        repeat (3) step(0, 0, 1);

        // Flush with nothing assembled, then popping resumes.
        step(0, 1, 1);
        for (int i = 0; i < 4; i++) src_q.push_back(DSIZE'(8'h30 + i));
        repeat (8) step(0, 0, 1);

        // Backpressure: exactly two words' worth of pops while the sink stalls.
        for (int i = 0; i < 12; i++) src_q.push_back(DSIZE'(8'h40 + i));
        rinc_seen = 0;
        repeat (16) step(0, 0, 0);
        check_eq("t5_pops", 64'(rinc_seen), 64'd8);
        repeat (12) step(0, 0, 1);

        // Reset with three words assembled.
        for (int i = 0; i < 3; i++) src_q.push_back(DSIZE'(8'h60 + i));
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        #1 check_eq("t6_word_cnt", 64'(word_cnt), 64'd0);
        for (int i = 0; i < 4; i++) src_q.push_back(DSIZE'(8'h70 + i));
        repeat (6) step(0, 0, 0);
        #1 check_eq("t6_data", 64'(m_data), 64'h73727170);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if (src_q.size() < 16 && $urandom_range(0, 99) < 60) src_q.push_back(DSIZE'($urandom));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 70));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
